// File: rtl/ps2_arrow_key_sequencer.sv
`default_nettype none
// ==== ps2_arrow_key_sequencer: PS/2 arrow make/break decoder, held bitmap, press-event FIFO ====
// ==== Optional: define PS2_SEQ_TYPEMATIC_EN to queue auto-repeat makes too.  Rev 1.0        ====
module ps2_arrow_key_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       check_input,
  output logic [3:0] held,
  output logic       event_valid,
  output logic [1:0] event_key,
  input  logic       event_ready,
  output logic       overflow
);

  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [c_TW-1:0] c_TIMEOUT_LAST = c_TW'(PREFIX_TIMEOUT - 1);
  localparam logic [c_AW:0]   c_DEPTH        = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [c_AW:0]   c_ONE          = (c_AW + 1)'(1);
  localparam logic [7:0]      c_EXT_CODE     = 8'hE0;
  localparam logic [7:0]      c_BRK_CODE     = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t            r_state, w_state_next;
  logic [c_TW-1:0]   r_timer;
  logic [3:0]        r_held;
  logic [1:0]        r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_AW:0]     r_count;
  logic              r_event_valid;
  logic [1:0]        r_event_key;
  logic              r_overflow;

  logic              w_is_arrow;
  logic [1:0]        w_arrow_key;
  logic              w_make, w_break, w_timeout;
  logic              w_push, w_pop, w_full, w_push_ok;
  logic [c_AW:0]     w_count_next;
  logic [c_AW-1:0]   w_rd_next;
  logic [1:0]        w_head_next;

  always_comb begin
    w_is_arrow  = 1'b1;
    w_arrow_key = 2'd0;
    case (received_data)
      8'h6B:   w_arrow_key = 2'd0;
      8'h74:   w_arrow_key = 2'd1;
      8'h72:   w_arrow_key = 2'd2;
      8'h75:   w_arrow_key = 2'd3;
      default: w_is_arrow  = 1'b0;
    endcase
  end

  assign w_timeout = (r_state != ST_IDLE) && (r_timer == c_TIMEOUT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // A strobe always wins over a timeout landing in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_make       = 1'b0;
    w_break      = 1'b0;
    if (received_data_en) begin
      case (r_state)
        ST_IDLE: begin
          if (received_data == c_EXT_CODE)      w_state_next = ST_EXT;
          else if (received_data == c_BRK_CODE) w_state_next = ST_BRK;
          else                                  w_state_next = ST_IDLE;
        end
        ST_EXT: begin
          if (received_data == c_BRK_CODE)      w_state_next = ST_EXT_BRK;
          else if (received_data == c_EXT_CODE) w_state_next = ST_EXT;
          else begin
            w_make       = w_is_arrow;
            w_state_next = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          w_break      = w_is_arrow;
          w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                           r_timer <= '0;
    else if (received_data_en || w_timeout
             || r_state == ST_IDLE)      r_timer <= '0;
    else                                 r_timer <= r_timer + c_TW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_held <= 4'b0000;
    end else if (w_make) begin
      r_held[w_arrow_key] <= 1'b1;
    end else if (w_break) begin
      r_held[w_arrow_key] <= 1'b0;
    end
  end

`ifdef PS2_SEQ_TYPEMATIC_EN
  assign w_push = w_make && check_input;
`else
  assign w_push = w_make && check_input && !r_held[w_arrow_key];
`endif

  assign w_pop     = r_event_valid && event_ready;
  assign w_full    = (r_count == c_DEPTH);
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_rd_next = w_pop ? r_rd_ptr + c_AW'(1) : r_rd_ptr;

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop)      w_count_next = r_count + c_ONE;
    else if (!w_push_ok && w_pop) w_count_next = r_count - c_ONE;
  end

  // The new head may be the entry being written this very cycle.
  assign w_head_next = (w_push_ok && (w_rd_next == r_wr_ptr)) ? w_arrow_key
                                                              : r_mem[w_rd_next];

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_arrow_key;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_event_valid <= 1'b0;
      r_event_key   <= 2'd0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      r_rd_ptr      <= w_rd_next;
      r_count       <= w_count_next;
      r_event_valid <= (w_count_next != '0);
      r_event_key   <= (w_count_next != '0) ? w_head_next : 2'd0;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign held        = r_held;
  assign event_valid = r_event_valid;
  assign event_key   = r_event_key;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_arrow_key_sequencer.sv
`default_nettype none
// ==== tb_ps2_arrow_key_sequencer: table-driven vectors plus timeout/overflow/reset sequences ====
// ==== Rev 1.0                                                                                ====
module tb_ps2_arrow_key_sequencer;

  localparam int c_TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       chk_in;
  logic [3:0] held;
  logic       ev_valid;
  logic [1:0] ev_key;
  logic       ev_ready;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  ps2_arrow_key_sequencer #(.FIFO_DEPTH(4), .PREFIX_TIMEOUT(c_TMO)) dut (
    .clock(clk), .reset(rst), .received_data(rx_data), .received_data_en(rx_en),
    .check_input(chk_in), .held(held), .event_valid(ev_valid), .event_key(ev_key),
    .event_ready(ev_ready), .overflow(ovf)
  );

  typedef struct {
    logic       en;
    logic [7:0] data;
    logic       chk;
    logic       rdy;
    logic [3:0] held;
    logic       valid;
    logic [1:0] key;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] codes [4];

  task automatic add(input logic en, input logic [7:0] d, input logic c, input logic r,
                     input logic [3:0] h, input logic v, input logic [1:0] k, input logic o);
    vec_t t;
    t.en = en; t.data = d; t.chk = c; t.rdy = r;
    t.held = h; t.valid = v; t.key = k; t.ovf = o;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {held, ev_valid, ev_key, ovf};
  endfunction

  // One cycle: inputs set on the falling edge, outputs sampled 1 time unit after the rising edge.
  task automatic cycle(input logic en, input logic [7:0] d, input logic c, input logic r);
    @(negedge clk);
    rx_en = en; rx_data = d; chk_in = c; ev_ready = r;
    @(posedge clk);
    #1;
    rx_en = 1'b0; ev_ready = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic c);
    cycle(1'b1, d, c, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press_release(input int k);
    send(8'hE0, 1'b1); send(codes[k], 1'b1);
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(codes[k], 1'b1);
  endtask

  initial begin
    codes[0] = 8'h6B; codes[1] = 8'h74; codes[2] = 8'h72; codes[3] = 8'h75;
    rst = 1'b1; rx_data = 8'h00; rx_en = 1'b0; chk_in = 1'b1; ev_ready = 1'b0;

    // {en, data, check_input, ready} -> {held, valid, key, overflow}
    add(1, 8'hE0, 1, 0, 4'h0, 0, 2'd0, 0);
    add(1, 8'h75, 1, 0, 4'h8, 1, 2'd3, 0);
    add(1, 8'hE0, 1, 0, 4'h8, 1, 2'd3, 0);
    add(1, 8'hF0, 1, 0, 4'h8, 1, 2'd3, 0);
    add(1, 8'h75, 1, 0, 4'h0, 1, 2'd3, 0);
    add(0, 8'h00, 1, 1, 4'h0, 0, 2'd0, 0);
    add(1, 8'hE0, 1, 0, 4'h0, 0, 2'd0, 0);   // typematic left x3
    add(1, 8'h6B, 1, 0, 4'h1, 1, 2'd0, 0);
    add(1, 8'hE0, 1, 0, 4'h1, 1, 2'd0, 0);
    add(1, 8'h6B, 1, 0, 4'h1, 1, 2'd0, 0);
    add(1, 8'hE0, 1, 0, 4'h1, 1, 2'd0, 0);
    add(1, 8'h6B, 1, 0, 4'h1, 1, 2'd0, 0);
    add(0, 8'h00, 1, 1, 4'h1, 0, 2'd0, 0);
    add(0, 8'h00, 1, 1, 4'h1, 0, 2'd0, 0);
    add(1, 8'hE0, 1, 0, 4'h1, 0, 2'd0, 0);
    add(1, 8'hF0, 1, 0, 4'h1, 0, 2'd0, 0);
    add(1, 8'h6B, 1, 0, 4'h0, 0, 2'd0, 0);
    add(1, 8'h1C, 1, 0, 4'h0, 0, 2'd0, 0);   // non-arrow traffic
    add(1, 8'hF0, 1, 0, 4'h0, 0, 2'd0, 0);
    add(1, 8'h1C, 1, 0, 4'h0, 0, 2'd0, 0);
    add(1, 8'hE0, 1, 0, 4'h0, 0, 2'd0, 0);
    add(1, 8'h1F, 1, 0, 4'h0, 0, 2'd0, 0);
    add(1, 8'hE0, 1, 0, 4'h0, 0, 2'd0, 0);
    add(1, 8'hF0, 1, 0, 4'h0, 0, 2'd0, 0);
    add(1, 8'h1F, 1, 0, 4'h0, 0, 2'd0, 0);
    add(1, 8'hE0, 1, 0, 4'h0, 0, 2'd0, 0);
    add(1, 8'h72, 1, 0, 4'h4, 1, 2'd2, 0);
    add(1, 8'hE0, 0, 0, 4'h4, 1, 2'd2, 0);   // right pressed with check_input low
    add(1, 8'h74, 0, 0, 4'h6, 1, 2'd2, 0);
    add(1, 8'hE0, 1, 0, 4'h6, 1, 2'd2, 0);
    add(1, 8'hF0, 1, 0, 4'h6, 1, 2'd2, 0);
    add(1, 8'h72, 1, 0, 4'h2, 1, 2'd2, 0);
    add(1, 8'hE0, 1, 0, 4'h2, 1, 2'd2, 0);
    add(1, 8'hF0, 1, 0, 4'h2, 1, 2'd2, 0);
    add(1, 8'h74, 1, 0, 4'h0, 1, 2'd2, 0);
    add(0, 8'h00, 1, 1, 4'h0, 0, 2'd0, 0);
    add(1, 8'hE0, 1, 1, 4'h0, 0, 2'd0, 0);   // push while empty with ready high
    add(1, 8'h75, 1, 1, 4'h8, 1, 2'd3, 0);
    add(1, 8'hE0, 1, 1, 4'h8, 0, 2'd0, 0);
    add(1, 8'hF0, 1, 0, 4'h8, 0, 2'd0, 0);
    add(1, 8'h75, 1, 0, 4'h0, 0, 2'd0, 0);

    do_reset();
    #1 check("reset_state", outs(), 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].en, vecs[i].data, vecs[i].chk, vecs[i].rdy);
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].held, vecs[i].valid, vecs[i].key, vecs[i].ovf});
    end

    // Prefix timeout: a make just inside the window still counts.
    send(8'hE0, 1'b1);
    repeat (8) @(posedge clk);
    send(8'h6B, 1'b1);
    check("make_before_timeout", outs(), {4'h1, 1'b1, 2'd0, 1'b0});
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h6B, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("drain_before_timeout", outs(), 8'h00);

    send(8'hE0, 1'b1);
    repeat (c_TMO + 2) @(posedge clk);
    send(8'h6B, 1'b1);
    check("timeout_abandons_ext", outs(), 8'h00);
    send(8'hE0, 1'b0); send(8'h74, 1'b0);
    check("right_no_event", outs(), {4'h2, 1'b0, 2'd0, 1'b0});
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h74, 1'b1);
    check("right_release", outs(), 8'h00);

    // Five rounds into a depth-4 queue: first round fills it, the rest overflow.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 4; k++) press_release(k);
      if (c == 0) check("full_no_overflow", outs(), {4'h0, 1'b1, 2'd0, 1'b0});
    end
    check("overflow_set", outs(), {4'h0, 1'b1, 2'd0, 1'b1});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("pop_order%0d", i), {5'd0, ev_valid, ev_key}, {5'd0, 1'b1, 2'(i)});
      ev_ready = 1'b1;
      @(posedge clk);
      #1 ev_ready = 1'b0;
    end
    check("drained_overflow_sticky", outs(), {4'h0, 1'b0, 2'd0, 1'b1});

    // Simultaneous push and pop while full.
    do_reset();
    for (int k = 0; k < 4; k++) press_release(k);
    send(8'hE0, 1'b1);
    cycle(1'b1, 8'h75, 1'b1, 1'b1);
    check("full_push_pop", outs(), {4'h8, 1'b1, 2'd1, 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("pp_order%0d", i), {5'd0, ev_valid, ev_key},
            {5'd0, 1'b1, (i == 3) ? 2'd3 : 2'(i + 1)});
      ev_ready = 1'b1;
      @(posedge clk);
      #1 ev_ready = 1'b0;
    end
    check("pp_drained", outs(), {4'h8, 1'b0, 2'd0, 1'b0});

    // Asynchronous reset mid break sequence with two queued events.
    do_reset();
    send(8'hE0, 1'b1); send(8'h6B, 1'b1);
    send(8'hE0, 1'b1); send(8'h74, 1'b1);
    send(8'hE0, 1'b1); send(8'hF0, 1'b1);
    check("pre_reset", outs(), {4'h3, 1'b1, 2'd0, 1'b0});
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", outs(), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    send(8'h74, 1'b1);
    check("byte_after_reset", outs(), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_arrow_key_sequencer.md
# ps2_arrow_key_sequencer

Decodes the PS/2 scan-code byte stream from `PS2_Controller` into arrow-key state for the Piano Tiles game logic. A make/break state machine tracks the E0 and F0 prefixes and keeps a held-key bitmap. New key presses are queued in a small FIFO, and the game consumer drains that FIFO through a valid/ready handshake. The block sits between `PS2_Controller` (`received_data`/`received_data_en`) and the lane-checking logic.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: event queue depth. Must be a power of 2, ≥2.
- `PREFIX_TIMEOUT`, default 1_000_000: cycles allowed between prefix bytes before the FSM abandons a partial sequence (20 ms at 50 MHz).

Ports:
- `clock` in 1: 50 MHz system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `received_data` in 8: scan-code byte. Valid only when `received_data_en`=1.
- `received_data_en` in 1: one-cycle strobe per received byte.
- `check_input` in 1: when 0, press events are not queued. `held` still tracks.
- `held` out 4: current key state. [0]=left, [1]=right, [2]=down, [3]=up.
- `event_valid` out 1: FIFO head holds a press event.
- `event_key` out 2: key of head event. 0=left, 1=right, 2=down, 3=up.
- `event_ready` in 1: consumer accepts the head event when `event_valid`=1.
- `overflow` out 1: sticky. Set when an event is dropped because the FIFO is full.

## Operation
- Arrow codes, all E0-prefixed:
  - left = 6B
  - right = 74
  - down = 72
  - up = 75
- Break sequence is E0 F0 xx.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions act only on cycles with `received_data_en`=1.
- From IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - Any other byte → IDLE. The byte is ignored (non-extended keys are not tracked).
- From EXT:
  - F0 → EXT_BRK.
  - E0 → EXT.
  - Arrow code → make action, then IDLE.
  - Any other byte → IDLE.
- From BRK: any byte → IDLE. It is a non-extended break and is ignored.
- From EXT_BRK:
  - Arrow code → clear the matching `held` bit, then IDLE.
  - Any other byte → IDLE.
- Make action:
  - Set the matching `held` bit.
  - If the bit was previously 0 and `check_input`=1, push `event_key` into the FIFO.
- Typematic repeats (make of a key already held) push nothing, unless `PS2_SEQ_TYPEMATIC_EN` is defined.
- Prefix timeout:
  - A counter is cleared on every strobe and increments while in EXT, BRK or EXT_BRK.
  - When it reaches `PREFIX_TIMEOUT`-1 the FSM returns to IDLE. `held` is unchanged.
- FIFO:
  - `event_valid` = not empty. A pop occurs when `event_valid` & `event_ready`.
  - A push while full drops the event and sets `overflow`.
  - A simultaneous push and pop while full is accepted with no overflow; count is unchanged.
  - A simultaneous push and pop while empty pushes; no pop occurs.
- Multiple keys may be held at once. Events are queued in arrival order.

## Timing
- Reset values: `held`=0000, `event_valid`=0, `event_key`=0, `overflow`=0. FSM = IDLE, FIFO empty, timeout counter = 0.
- Reset may assert at any time, including mid-sequence or mid-handshake. All state clears immediately and asynchronously.
- All outputs are registered.
- Latency: final byte strobed in cycle T gives:
  - `held` updated at T+1.
  - `event_valid`=1 at T+1 if the FIFO was empty.
- Pop in cycle T: the next head (or `event_valid`=0) is presented at T+1.
- `event_key` is stable while `event_valid`=1 and `event_ready`=0.
- Back-to-back strobes in consecutive cycles are processed fully, one byte per cycle.

## Configuration
- `PS2_SEQ_TYPEMATIC_EN` defined: every make of an arrow key pushes an event when `check_input`=1, including auto-repeat makes of a key already held.
- Not defined: only 0→1 transitions of a `held` bit push events.
- `held` behaviour is identical in both builds.

## Test plan
- Reset release, then bytes E0,75 with `check_input`=1 and `event_ready`=0 → at T+1 `held`=1000, `event_valid`=1, `event_key`=3. Then E0,F0,75 → `held`=0000 and the event remains queued.
- E0,6B sent three times (typematic), then `event_ready`=1 → exactly one pop with `event_key`=0. With `PS2_SEQ_TYPEMATIC_EN` defined: three pops, each `event_key`=0.
- With `event_ready`=0, press and release each arrow cycling 5 times (FIFO_DEPTH=4) → 4 events held in order 0,1,2,3; `overflow`=1. Then assert `event_ready` for 4 cycles → `event_valid` drops.
- Non-arrow traffic: 1C, F0,1C, E0,1F, E0,F0,1F → `held`=0000, no events. Then E0,72 → `held`=0100, `event_key`=2.
- Send E0, wait `PREFIX_TIMEOUT` cycles, send 6B → no change, no event. Repeat with `check_input`=0 and E0,74 → `held`=0010, no event.
- Assert `reset` mid-sequence (after E0,F0) while the FIFO holds 2 events → all outputs return to reset values in the same cycle. A following 74 is ignored.
